// File: rtl/joy_sega_multi_reader_if.sv
// Bus bundle for joy_sega_multi_reader: tick/frame strobes toward the UI side,
// shift-register and select pins toward the DB9 ports, plus an FSM debug view.
interface joy_sega_multi_reader_if #(
    parameter int NUM_PORTS = 2
);
    // tick_i is a one-cycle request taken only while idle (dropped otherwise);
    // frame_valid_o is a one-cycle publish strobe with no back-pressure.
    logic                      tick_i;
    logic                      joy_data_i;
    logic                      joy_clk_o;
    logic                      joy_load_n_o;
    logic                      select_o;
    logic [12*NUM_PORTS-1:0]   joy_o;
    logic [NUM_PORTS-1:0]      six_btn_o;
    logic                      frame_valid_o;
    logic                      busy_o;
    logic [2:0]                state_o;

    modport master (
        input  tick_i, joy_data_i,
        output joy_clk_o, joy_load_n_o, select_o, joy_o, six_btn_o,
               frame_valid_o, busy_o, state_o
    );

    modport slave (
        output tick_i, joy_data_i,
        input  joy_clk_o, joy_load_n_o, select_o, joy_o, six_btn_o,
               frame_valid_o, busy_o, state_o
    );
endinterface

// File: rtl/joy_sega_multi_reader.sv
// Multi-port DB9 Megadrive pad reader over one chained PISO shift register.
// Define JOY_SEGA6_EN for the 8-step select sequence and 6-button decoding.
module joy_sega_multi_reader #(
    parameter int NUM_PORTS = 2,
    parameter int CLK_DIV   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    joy_sega_multi_reader_if.master  bus
);
    localparam int NBITS = 8 * NUM_PORTS;
    localparam int BW    = $clog2(NBITS);
    localparam int DW    = $clog2(CLK_DIV);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT_LO, SHIFT_HI, DECODE} state_t;

    state_t                  state;
    logic [DW-1:0]           div_cnt;
    logic [BW-1:0]           bit_cnt;
    // Only the six meaningful bits of each port are kept; the two X bits pass by.
    logic [6*NUM_PORTS-1:0]  raw;
    logic                    joy_clk;
    logic                    load_n;
    logic                    busy;
    logic                    frame_valid;
    logic [12*NUM_PORTS-1:0] joy;
    logic                    div_end;

    assign div_end = (div_cnt == DW'(CLK_DIV - 1));

`ifdef JOY_SEGA6_EN
    logic [2:0]              step;
    logic                    sel;
    logic [12*NUM_PORTS-1:0] shadow;
    logic [NUM_PORTS-1:0]    six_det;
    logic [NUM_PORTS-1:0]    six_btn;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            raw         <= '0;
            joy_clk     <= 1'b1;
            load_n      <= 1'b1;
            busy        <= 1'b0;
            frame_valid <= 1'b0;
            joy         <= '0;
`ifdef JOY_SEGA6_EN
            step        <= '0;
            sel         <= 1'b1;
            shadow      <= '0;
            six_det     <= '0;
            six_btn     <= '0;
`endif
        end else begin
            frame_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.tick_i) begin
                        state   <= LOAD;
                        busy    <= 1'b1;
                        load_n  <= 1'b0;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                LOAD: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        load_n  <= 1'b1;
                        joy_clk <= 1'b0;
                        state   <= SHIFT_LO;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (bit_cnt[2:0] < 3'd6) begin
                            raw <= {bus.joy_data_i, raw[6*NUM_PORTS-1:1]};
                        end
                        joy_clk <= 1'b1;
                        state   <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == BW'(NBITS - 1)) begin
                            state <= DECODE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            joy_clk <= 1'b0;
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DECODE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
`ifdef JOY_SEGA6_EN
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        case (step)
                            3'd0: shadow[12*p +: 6] <= ~raw[6*p +: 6];
                            3'd1: begin
                                shadow[12*p + 6] <= ~raw[6*p + 4];
                                shadow[12*p + 7] <= ~raw[6*p + 5];
                            end
                            3'd5: six_det[p] <= (raw[6*p +: 4] == 4'b0000);
                            3'd6: shadow[12*p + 8 +: 4] <= six_det[p] ? ~raw[6*p +: 4] : 4'b0000;
                            default: ;
                        endcase
                    end
                    // Incrementing flips step[0], so ~new_step[0] equals old step[0].
                    step <= step + 3'd1;
                    sel  <= step[0];
                    if (step == 3'd7) begin
                        joy         <= shadow;
                        six_btn     <= six_det;
                        six_det     <= '0;
                        frame_valid <= 1'b1;
                    end
`else
                    for (int p = 0; p < NUM_PORTS; p++) begin
                        joy[12*p +: 12] <= {6'b000000, ~raw[6*p +: 6]};
                    end
                    frame_valid <= 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.joy_clk_o     = joy_clk;
    assign bus.joy_load_n_o  = load_n;
    assign bus.busy_o        = busy;
    assign bus.frame_valid_o = frame_valid;
    assign bus.joy_o         = joy;
    assign bus.state_o       = state;
`ifdef JOY_SEGA6_EN
    assign bus.select_o      = sel;
    assign bus.six_btn_o     = six_btn;
`else
    assign bus.select_o      = 1'b1;
    assign bus.six_btn_o     = '0;
`endif
endmodule

// File: tb/tb_joy_sega_multi_reader.sv
// Bench for joy_sega_multi_reader: behavioural pads behind a PISO chain model,
// directed frames, a reset mid-scan, a tick storm and randomized frames.
module tb_joy_sega_multi_reader;
  localparam int NP = 2;
  localparam int CD = 4;
  localparam int NB = 8 * NP;
  localparam int W  = 12 * NP;
  localparam int SCAN_CYC = CD * (1 + 16 * NP) + 1;
`ifdef JOY_SEGA6_EN
  localparam bit SEGA6 = 1'b1;
`else
  localparam bit SEGA6 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  joy_sega_multi_reader_if #(.NUM_PORTS(NP)) bus();

  joy_sega_multi_reader #(.NUM_PORTS(NP), .CLK_DIV(CD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Pad kinds: 0 = nothing plugged, 1 = 3-button, 2 = 6-button.
  int          pad_kind[NP];
  logic [11:0] pad_press[NP];
  int          model_step = 0;
  logic [NB-1:0] chain = '1;
  int          idx = 0;
  logic [W-1:0]  pub_w;
  logic [NP-1:0] pub_six;

  // Active-low pad lines U,D,L,R,P6,P9,-,- for a given select step.
  function automatic logic [7:0] pad_bits(input int kind, input logic [11:0] p, input int step);
    logic [7:0] a;
    a = 8'h00;
    if (kind == 0) return 8'hFF;
    if (step % 2 == 0) begin
      if (kind == 2 && step == 6) a[3:0] = p[11:8];
      else a[3:0] = p[3:0];
      a[4] = p[4];
      a[5] = p[5];
    end else begin
      if (kind == 2 && step == 5) a[3:0] = 4'hF;
      else if (kind == 2 && step == 7) a[3:0] = 4'h0;
      else a[3:0] = {2'b11, p[1:0]};
      a[4] = p[6];
      a[5] = p[7];
    end
    return ~a;
  endfunction

  function automatic logic [11:0] exp_word(input int kind, input logic [11:0] p);
    if (kind == 0) return 12'h000;
    if (!SEGA6) return p & 12'h03F;
    if (kind == 1) return p & 12'h0FF;
    return p;
  endfunction

  always @(negedge bus.joy_load_n_o) begin
    for (int p = 0; p < NP; p++) chain[8*p +: 8] = pad_bits(pad_kind[p], pad_press[p], model_step);
    idx = 0;
    if (SEGA6) model_step = (model_step + 1) % 8;
  end

  always @(posedge bus.joy_clk_o) idx++;

  assign bus.joy_data_i = (idx < NB) ? chain[idx] : 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_joy"},   64'(bus.joy_o), 64'(0));
    check({tag, "_six"},   64'(bus.six_btn_o), 64'(0));
    check({tag, "_fv"},    64'(bus.frame_valid_o), 64'(0));
    check({tag, "_busy"},  64'(bus.busy_o), 64'(0));
    check({tag, "_clk"},   64'(bus.joy_clk_o), 64'(1));
    check({tag, "_load"},  64'(bus.joy_load_n_o), 64'(1));
    check({tag, "_sel"},   64'(bus.select_o), 64'(1));
  endtask

  task automatic run_scan(output int busy_c, output int load_c, output int low_c,
                          output int falls, output int fv_c);
    logic prev_clk;
    busy_c = 0; load_c = 0; low_c = 0; falls = 0; fv_c = 0;
    prev_clk = 1'b1;
    @(negedge clk); bus.tick_i = 1'b1;
    @(negedge clk); bus.tick_i = 1'b0;
    for (int n = 0; n < 4 * SCAN_CYC; n++) begin
      if (bus.frame_valid_o) fv_c++;
      if (!bus.busy_o) break;
      busy_c++;
      if (!bus.joy_load_n_o) load_c++;
      if (!bus.joy_clk_o) low_c++;
      if (prev_clk && !bus.joy_clk_o) falls++;
      prev_clk = bus.joy_clk_o;
      @(negedge clk);
    end
    check("scan_done", 64'(bus.busy_o), 64'(0));
  endtask

  task automatic run_frame(input string tag, input int first_step,
                           input logic [W-1:0] exp_w, input logic [NP-1:0] exp_six);
    int b, l, lo, f, fv, last;
    last = SEGA6 ? 8 : first_step + 1;
    for (int s = first_step; s < last; s++) begin
      check({tag, "_select"}, 64'(bus.select_o), 64'((SEGA6 && s % 2 == 1) ? 0 : 1));
      run_scan(b, l, lo, f, fv);
      check({tag, "_busy_len"}, 64'(b), 64'(SCAN_CYC));
      check({tag, "_load_len"}, 64'(l), 64'(CD));
      check({tag, "_clk_low"},  64'(lo), 64'(CD * NB));
      check({tag, "_clk_pulses"}, 64'(f), 64'(NB));
      check({tag, "_fv_count"}, 64'(fv), 64'((s == last - 1) ? 1 : 0));
      if (s != last - 1) begin
        check({tag, "_hold_joy"}, 64'(bus.joy_o), 64'(pub_w));
        check({tag, "_hold_six"}, 64'(bus.six_btn_o), 64'(pub_six));
      end
    end
    check({tag, "_joy"}, 64'(bus.joy_o), 64'(exp_w));
    check({tag, "_six"}, 64'(bus.six_btn_o), 64'(exp_six));
    pub_w = exp_w;
    pub_six = exp_six;
  endtask

  initial begin
    int b, l, lo, f, fv, starts, fvs;
    logic prev_busy;
    logic [W-1:0] ew;
    logic [NP-1:0] es;
    bus.tick_i = 1'b0;
    for (int p = 0; p < NP; p++) begin pad_kind[p] = 0; pad_press[p] = 12'h000; end
    pub_w = '0;
    pub_six = '0;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    rst = 1'b0;
    @(negedge clk);

    pad_kind[0] = 1; pad_press[0] = 12'h040;
    run_frame("a_only", 0, {12'h000, SEGA6 ? 12'h040 : 12'h000}, 2'b00);

    pad_kind[0] = 0; pad_press[0] = 12'h000;
    pad_kind[1] = 2; pad_press[1] = 12'h108;
    run_frame("z_right", 0, {SEGA6 ? 12'h108 : 12'h008, 12'h000}, {SEGA6, 1'b0});

    for (int k = 0; k < 3; k++) run_scan(b, l, lo, f, fv);
    @(negedge clk); bus.tick_i = 1'b1;
    @(negedge clk); bus.tick_i = 1'b0;
    repeat (40) @(negedge clk);
    check("mid_busy", 64'(bus.busy_o), 64'(1));
    rst = 1'b1;
    #1;
    check_reset("mid_rst");
    model_step = 0;
    pub_w = '0;
    pub_six = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    pad_kind[0] = 1; pad_press[0] = 12'h010;
    pad_kind[1] = 0; pad_press[1] = 12'h000;
    run_frame("b_only", 0, {12'h000, 12'h010}, 2'b00);

    starts = 0; fvs = 0; prev_busy = bus.busy_o;
    bus.tick_i = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (bus.busy_o && !prev_busy) starts++;
      if (bus.frame_valid_o) fvs++;
      prev_busy = bus.busy_o;
    end
    bus.tick_i = 1'b0;
    for (int n = 0; n < 2 * SCAN_CYC; n++) begin
      if (!bus.busy_o) break;
      @(negedge clk);
      if (bus.frame_valid_o) fvs++;
    end
    check("storm_idle", 64'(bus.busy_o), 64'(0));
    check("storm_starts", 64'(starts), 64'(3));
    check("storm_fv", 64'(fvs), 64'(SEGA6 ? 0 : 3));
    run_frame("post_storm", SEGA6 ? 3 : 0, {12'h000, 12'h010}, 2'b00);

    for (int fr = 0; fr < 6; fr++) begin
      for (int p = 0; p < NP; p++) begin
        pad_kind[p] = int'($urandom_range(0, 2));
        pad_press[p] = 12'($urandom_range(0, 4095));
        if (pad_kind[p] == 1 && pad_press[p][0] && pad_press[p][1]) pad_press[p][1] = 1'b0;
        ew[12*p +: 12] = exp_word(pad_kind[p], pad_press[p]);
        es[p] = SEGA6 && (pad_kind[p] == 2);
      end
      run_frame("rand", 0, ew, es);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
